regblock_pp: RTL
================

Name: regblock_pp

Overview:
- Next-generation CPU register block.
- Holds the full MC6809 register set and, when HD6309=1, the HD6309 extension registers E, F (W) and V.
- Provides two combinational read ports, one external write port and a flag write port.
- Contains an autonomous push/pull sequencer that executes PSHS/PSHU/PULS/PULU (plus PSHSW/PULSW-style W transfer) byte-by-byte over a memory request/acknowledge handshake, so the core's microsequencer no longer iterates stack postbytes itself.

Parameters:
- HD6309, 1: enables the W (E:F) and V registers and the zero-register codes.
- RESET_PC, 16'hFFFE: PC value at reset.
- RESET_S, 16'h0F00: S value at reset.
- RESET_U, 16'h0E00: U value at reset.

Ports:
- clk_in  in  1  clock, rising edge
- rst_in  in  1  asynchronous reset, active-high
- rd_a_addr  in  4  read port A register code
- rd_b_addr  in  4  read port B register code
- rd_a_data  out  16  read port A data, combinational
- rd_b_data  out  16  read port B data, combinational
- wr_en  in  1  external register write strobe
- wr_addr  in  4  external write register code
- wr_data  in  16  external write data (8-bit registers take [7:0])
- write_flags  in  1  load CCR from ccr_in
- ccr_in  in  8  new CCR value
- ccr_o  out  8  current CCR
- reg_pc  out  16  current PC
- reg_su  out  16  S when use_s=1, else U
- use_s  in  1  selects the stack for reg_su and for a started sequence
- pp_start  in  1  one-cycle start pulse for a push/pull sequence
- pp_pull  in  1  1 = pull, 0 = push; sampled with pp_start
- pp_mask  in  9  [7:0] standard 6809 postbyte; [8] = W (ignored when HD6309=0)
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse when a sequence completes
- mem_req  out  1  memory byte request
- mem_we  out  1  1 = write (push), 0 = read (pull)
- mem_addr  out  16  byte address
- mem_wdata  out  8  push data
- mem_rdata  in  8  pull data, valid with mem_ack
- mem_ack  in  1  completes the current request

Behaviour:
- Register codes: 0 D, 1 X, 2 Y, 3 U, 4 S, 5 PC, 6 W, 7 V, 8 A, 9 B, 10 CC, 11 DP, 12/13 zero, 14 E, 15 F.
- Reads of 8-bit registers return {8'hFF, reg}; DP and CC return {r, r}; codes 12/13 return 16'h0000.
- When HD6309=0:
  - codes 6, 7, 14 and 15 read 16'hFFFF and ignore writes;
  - codes 12/13 read 16'hFFFF.
- Writes to 12/13 are always ignored.
- Reset values: PC=RESET_PC, S=RESET_S, U=RESET_U, all other registers and CCR = 0. Outputs: busy=0, done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Same-edge write priority (lowest to highest): wr_en, write_flags, sequencer update.
- While busy=1, wr_en and write_flags are ignored, and pp_start is ignored.
- FSM states: IDLE, SCAN, ACCESS, FIN.
- IDLE:
  - pp_start latches mask, direction and stack (use_s) into internal state, then goes to SCAN. busy=1 from the next cycle.
  - If the latched mask is zero, the FSM goes IDLE -> SCAN -> FIN -> IDLE.
- SCAN: selects the next byte in sequence order, or goes to FIN if none remain. Takes one cycle.
- ACCESS:
  - mem_req=1, with address and data stable until mem_ack; mem_ack may arrive in the same cycle mem_req rises.
  - Push: mem_addr = SP-1, mem_wdata = selected byte; on ack, SP <= SP-1.
  - Pull: mem_addr = SP; on ack, the byte is written into the selected register half and SP <= SP+1.
  - SP arithmetic wraps modulo 2^16.
  - After ack, the FSM returns to SCAN.
- FIN: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
- Push byte order: W (F then E), PC lo/hi, U-or-S lo/hi, Y lo/hi, X lo/hi, DP, B, A, CC.
- Pull byte order is the exact reverse; 16-bit registers are pulled hi then lo.
- Mask bit 6 names the opposite stack pointer: U for an S sequence, S for a U sequence.
- Pulling a register updates it per byte, so a register is partially updated mid-sequence.
- Latency for an N-byte sequence with zero-wait ack: 2N+2 cycles from pp_start to done.
- rst_in asserted mid-sequence: the FSM goes to IDLE and all registers and outputs take reset values immediately; the partial transfer is abandoned.

Test Plan:
- Reset: assert rst_in mid-clock -> PC=FFFE, S=0F00, U=0E00, ccr_o=00, rd_a_data(code 8)=FF00, busy=0.
- Push: A=12, B=34, X=5678, S=0F00, pp_mask=0x16, zero-wait ack -> writes 0EFF=78, 0EFE=56, 0EFD=34, 0EFC=12; S=0EFC; done at cycle 10.
- Pull with wait states: memory 0EFC..0EFF = 12,34,56,78, S=0EFC, pp_pull=1, mask 0x16, ack delayed 3 cycles -> A=12, B=34, X=5678, S=0F00; mem_addr stable while waiting.
- Zero mask and wrap: S=0000, push mask 0x80 with PC=ABCD -> writes FFFF=CD, FFFE=AB, S=FFFE. Zero mask -> done two cycles after start, no mem_req.
- HD6309: W=BEEF, pp_mask=0x100 push on S=0F00 -> 0EFF=EF, 0EFE=BE. Read code 12 -> 0000. With HD6309=0: read code 6 -> FFFF, bit 8 ignored.
- Contention and reset: wr_en to X and a second pp_start during busy -> both ignored. rst_in during the 3rd byte -> busy=0, mem_req=0, S=0F00.

Source files
------------

// File: rtl/regblock_pp.sv
// regblock_pp: MC6809 / HD6309 register file with an autonomous push/pull
// sequencer that moves stack postbyte registers one byte at a time over a
// req/ack memory handshake.
//
// Ports:
//   clk_in, rst_in                  clock (rising), async active-high reset
//   rd_a_addr/rd_a_data             combinational read port A
//   rd_b_addr/rd_b_data             combinational read port B
//   wr_en/wr_addr/wr_data           external register write
//   write_flags/ccr_in, ccr_o       CCR load / current CCR
//   reg_pc, reg_su, use_s           PC, selected stack pointer, stack select
//   pp_start/pp_pull/pp_mask        push/pull sequence request
//   busy, done                      sequence status
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_rdata/mem_ack     byte memory handshake
module regblock_pp #(
    parameter int          HD6309   = 1,
    parameter logic [15:0] RESET_PC = 16'hFFFE,
    parameter logic [15:0] RESET_S  = 16'h0F00,
    parameter logic [15:0] RESET_U  = 16'h0E00
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [3:0]  rd_a_addr,
    input  logic [3:0]  rd_b_addr,
    output logic [15:0] rd_a_data,
    output logic [15:0] rd_b_data,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic        write_flags,
    input  logic [7:0]  ccr_in,
    output logic [7:0]  ccr_o,
    output logic [15:0] reg_pc,
    output logic [15:0] reg_su,
    input  logic        use_s,
    input  logic        pp_start,
    input  logic        pp_pull,
    input  logic [8:0]  pp_mask,
    output logic        busy,
    output logic        done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack
);
    localparam logic EXT = (HD6309 != 0);

    typedef enum logic [1:0] {IDLE, SCAN, ACCESS, FIN} state_t;

    state_t      state_q, state_d;
    logic [13:0] pend_q, pend_d;   // byte slots still to transfer, 0 = pushed first
    logic [3:0]  sel_q, sel_d;     // slot being transferred in ACCESS
    logic        pull_q, pull_d;
    logic        ss_q, ss_d;       // 1 = sequence runs on S

    logic [7:0]  a_q, a_d, b_q, b_d, e_q, e_d, f_q, f_d, cc_q, cc_d, dp_q, dp_d;
    logic [15:0] x_q, x_d, y_q, y_d, u_q, u_d, s_q, s_d, pc_q, pc_d, v_q, v_d;

    logic [15:0] sp, osp;          // active and opposite stack pointer
    logic [3:0]  nxt;
    logic        found;
    logic        ack_fire;

    assign sp       = ss_q ? s_q : u_q;
    assign osp      = ss_q ? u_q : s_q;
    assign busy     = (state_q == SCAN) || (state_q == ACCESS);
    assign done     = (state_q == FIN);
    assign mem_req  = (state_q == ACCESS);
    assign mem_we   = mem_req && !pull_q;
    assign ack_fire = mem_req && mem_ack;
    assign ccr_o    = cc_q;
    assign reg_pc   = pc_q;
    assign reg_su   = use_s ? s_q : u_q;

    function automatic logic [15:0] rdreg(input logic [3:0] c);
        case (c)
            4'd0:  rdreg = {a_q, b_q};
            4'd1:  rdreg = x_q;
            4'd2:  rdreg = y_q;
            4'd3:  rdreg = u_q;
            4'd4:  rdreg = s_q;
            4'd5:  rdreg = pc_q;
            4'd6:  rdreg = EXT ? {e_q, f_q} : 16'hFFFF;
            4'd7:  rdreg = EXT ? v_q : 16'hFFFF;
            4'd8:  rdreg = {8'hFF, a_q};
            4'd9:  rdreg = {8'hFF, b_q};
            4'd10: rdreg = {cc_q, cc_q};
            4'd11: rdreg = {dp_q, dp_q};
            4'd14: rdreg = EXT ? {8'hFF, e_q} : 16'hFFFF;
            4'd15: rdreg = EXT ? {8'hFF, f_q} : 16'hFFFF;
            default: rdreg = EXT ? 16'h0000 : 16'hFFFF;
        endcase
    endfunction

    // Slot map: 0 F, 1 E, 2/3 PC lo/hi, 4/5 opposite SP lo/hi, 6/7 Y, 8/9 X,
    // 10 DP, 11 B, 12 A, 13 CC. Push walks up, pull walks down.
    function automatic logic [7:0] slot_byte(input logic [3:0] sl);
        case (sl)
            4'd0:  slot_byte = f_q;
            4'd1:  slot_byte = e_q;
            4'd2:  slot_byte = pc_q[7:0];
            4'd3:  slot_byte = pc_q[15:8];
            4'd4:  slot_byte = osp[7:0];
            4'd5:  slot_byte = osp[15:8];
            4'd6:  slot_byte = y_q[7:0];
            4'd7:  slot_byte = y_q[15:8];
            4'd8:  slot_byte = x_q[7:0];
            4'd9:  slot_byte = x_q[15:8];
            4'd10: slot_byte = dp_q;
            4'd11: slot_byte = b_q;
            4'd12: slot_byte = a_q;
            default: slot_byte = cc_q;
        endcase
    endfunction

    assign rd_a_data = rdreg(rd_a_addr);
    assign rd_b_data = rdreg(rd_b_addr);
    assign mem_addr  = mem_req ? (pull_q ? sp : sp - 16'd1) : 16'h0000;
    assign mem_wdata = mem_we ? slot_byte(sel_q) : 8'h00;

    // Push takes the lowest pending slot, pull the highest.
    always_comb begin
        found = 1'b0;
        nxt   = 4'd0;
        for (int i = 0; i < 14; i++) begin
            if (pend_q[i] && (pull_q || !found)) begin
                nxt   = i[3:0];
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        sel_d   = sel_q;
        pull_d  = pull_q;
        ss_d    = ss_q;
        case (state_q)
            IDLE: if (pp_start) begin
                pend_d  = {pp_mask[0], pp_mask[1], pp_mask[2], pp_mask[3],
                           {2{pp_mask[4]}}, {2{pp_mask[5]}}, {2{pp_mask[6]}},
                           {2{pp_mask[7]}}, {2{pp_mask[8] & EXT}}};
                pull_d  = pp_pull;
                ss_d    = use_s;
                state_d = SCAN;
            end
            SCAN: if (found) begin
                sel_d       = nxt;
                pend_d[nxt] = 1'b0;
                state_d     = ACCESS;
            end else begin
                state_d = FIN;
            end
            ACCESS: if (mem_ack) state_d = SCAN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_d = a_q; b_d = b_q; e_d = e_q; f_d = f_q; cc_d = cc_q; dp_d = dp_q;
        x_d = x_q; y_d = y_q; u_d = u_q; s_d = s_q; pc_d = pc_q; v_d = v_q;
        if (!busy && wr_en) begin
            case (wr_addr)
                4'd0:  begin a_d = wr_data[15:8]; b_d = wr_data[7:0]; end
                4'd1:  x_d  = wr_data;
                4'd2:  y_d  = wr_data;
                4'd3:  u_d  = wr_data;
                4'd4:  s_d  = wr_data;
                4'd5:  pc_d = wr_data;
                4'd6:  if (EXT) begin e_d = wr_data[15:8]; f_d = wr_data[7:0]; end
                4'd7:  if (EXT) v_d = wr_data;
                4'd8:  a_d  = wr_data[7:0];
                4'd9:  b_d  = wr_data[7:0];
                4'd10: cc_d = wr_data[7:0];
                4'd11: dp_d = wr_data[7:0];
                4'd14: if (EXT) e_d = wr_data[7:0];
                4'd15: if (EXT) f_d = wr_data[7:0];
                default: ;
            endcase
        end
        if (!busy && write_flags) cc_d = ccr_in;
        if (ack_fire) begin
            if (pull_q) begin
                case (sel_q)
                    4'd0:  f_d = mem_rdata;
                    4'd1:  e_d = mem_rdata;
                    4'd2:  pc_d[7:0]  = mem_rdata;
                    4'd3:  pc_d[15:8] = mem_rdata;
                    4'd4:  if (ss_q) u_d[7:0]  = mem_rdata; else s_d[7:0]  = mem_rdata;
                    4'd5:  if (ss_q) u_d[15:8] = mem_rdata; else s_d[15:8] = mem_rdata;
                    4'd6:  y_d[7:0]  = mem_rdata;
                    4'd7:  y_d[15:8] = mem_rdata;
                    4'd8:  x_d[7:0]  = mem_rdata;
                    4'd9:  x_d[15:8] = mem_rdata;
                    4'd10: dp_d = mem_rdata;
                    4'd11: b_d  = mem_rdata;
                    4'd12: a_d  = mem_rdata;
                    default: cc_d = mem_rdata;
                endcase
            end
            // Slots 4/5 never touch the active SP, so this cannot collide.
            if (ss_q) s_d = pull_q ? s_q + 16'd1 : s_q - 16'd1;
            else      u_d = pull_q ? u_q + 16'd1 : u_q - 16'd1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            pend_q  <= '0;
            sel_q   <= '0;
            pull_q  <= 1'b0;
            ss_q    <= 1'b0;
            a_q <= '0; b_q <= '0; e_q <= '0; f_q <= '0; cc_q <= '0; dp_q <= '0;
            x_q <= '0; y_q <= '0; v_q <= '0;
            u_q  <= RESET_U;
            s_q  <= RESET_S;
            pc_q <= RESET_PC;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            sel_q   <= sel_d;
            pull_q  <= pull_d;
            ss_q    <= ss_d;
            a_q <= a_d; b_q <= b_d; e_q <= e_d; f_q <= f_d; cc_q <= cc_d; dp_q <= dp_d;
            x_q <= x_d; y_q <= y_d; u_q <= u_d; s_q <= s_d; pc_q <= pc_d; v_q <= v_d;
        end
    end
endmodule
